// File: rtl/dmem_lsu.sv
// Load/store sequencer for a 64-bit doubleword memory port: aligned dword
// cycles, read-modify-write for narrow stores, sign/zero-extended loads.
module dmem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    input  logic [63:0] Read_Data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [2:0]  off_reg;
    logic [63:0] wdata_reg;
    logic [63:0] captured_reg;
    logic [63:0] mem_addr_reg;
    logic [63:0] write_data_reg;
    logic [63:0] resp_rdata_reg;
    logic        resp_err_reg;

    logic        misaligned;
    logic [63:0] load_shifted;
    logic [63:0] load_value;
    logic [63:0] wdata_shifted;
    logic [63:0] merged;
    logic [7:0]  lane_en;
    logic [3:0]  nbytes;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = req_addr[0];
            2'd2: misaligned = |req_addr[1:0];
            2'd3: misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        load_shifted = Read_Data >> {off_reg, 3'b000};
        load_value   = load_shifted;
        case (size_reg)
            2'd0: load_value = unsigned_reg ? {56'd0, load_shifted[7:0]}
                                            : {{56{load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_value = unsigned_reg ? {48'd0, load_shifted[15:0]}
                                            : {{48{load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_value = unsigned_reg ? {32'd0, load_shifted[31:0]}
                                            : {{32{load_shifted[31]}}, load_shifted[31:0]};
            default: load_value = load_shifted;
        endcase
    end

    assign nbytes        = 4'd1 << size_reg;
    assign wdata_shifted = wdata_reg << {off_reg, 3'b000};

    // Store merge: lanes off..off+nbytes-1 take new data, the rest keep the
    // doubleword captured during RD.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);
            assign lane_en[gi] = (LANE >= {1'b0, off_reg}) && (LANE < ({1'b0, off_reg} + nbytes));
            assign merged[8*gi +: 8] = lane_en[gi] ? wdata_shifted[8*gi +: 8]
                                                   : captured_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned)                        state_next = S_RESP;
                    else if (req_write && req_size == 2'd3) state_next = S_WR;
                    else                                   state_next = S_RD;
                end
            end
            S_RD:    state_next = write_reg ? S_MERGE : S_RESP;
            S_MERGE: state_next = S_WR;
            S_WR:    state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            write_reg      <= 1'b0;
            size_reg       <= 2'd0;
            unsigned_reg   <= 1'b0;
            off_reg        <= 3'd0;
            wdata_reg      <= 64'd0;
            captured_reg   <= 64'd0;
            mem_addr_reg   <= 64'd0;
            write_data_reg <= 64'd0;
            resp_rdata_reg <= 64'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        write_reg    <= req_write;
                        size_reg     <= req_size;
                        unsigned_reg <= req_unsigned;
                        off_reg      <= req_addr[2:0];
                        wdata_reg    <= req_wdata;
                        if (misaligned) begin
                            resp_rdata_reg <= 64'd0;
                            resp_err_reg   <= 1'b1;
                        end else begin
                            mem_addr_reg <= {req_addr[63:3], 3'b000};
                            if (req_write && req_size == 2'd3)
                                write_data_reg <= req_wdata;
                        end
                    end
                end
                S_RD: begin
                    if (write_reg) begin
                        captured_reg <= Read_Data;
                    end else begin
                        resp_rdata_reg <= load_value;
                        resp_err_reg   <= 1'b0;
                    end
                end
                S_MERGE: write_data_reg <= merged;
                S_WR: begin
                    resp_rdata_reg <= 64'd0;
                    resp_err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_reg == S_IDLE);
    assign resp_valid = (state_reg == S_RESP);
    assign MemRead    = (state_reg == S_RD);
    assign MemWrite   = (state_reg == S_WR);
    assign Mem_Addr   = mem_addr_reg;
    assign Write_Data = write_data_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store sequencer that acts as the initiator for the 64-bit `Data_Memory` port (`MemRead`, `MemWrite`, `Mem_Addr`, `Write_Data`, `Read_Data`). It accepts one byte, half, word or doubleword load or store per handshake from the datapath. It converts that request into aligned doubleword memory cycles, using read-modify-write for sub-doubleword stores, and returns a sign- or zero-extended load result with a one-cycle response pulse.

## Interface
- No parameters; data and address widths are fixed at 64.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 doubleword.
- `req_unsigned` in 1: zero-extend load result; ignored for doubleword and stores.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 64: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned request; valid with `resp_valid`.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe; memory commits on the rising edge while high.
- `Mem_Addr` out 64: always doubleword-aligned (`addr & ~7`).
- `Write_Data` out 64: merged doubleword to write.
- `Read_Data` in 64: memory read data; valid combinationally during a `MemRead` cycle.

## Operation
- **Accept.** A request is accepted when `req_valid && req_ready`. All request fields are registered at accept.
- **Lane offset.** `off = addr[2:0]`, little-endian; byte lane k is `[8k+7:8k]`.
- **Misaligned request.** A request is misaligned when `addr` is not a multiple of the size: byte never; half when `addr[0]`; word when `addr[1:0]≠0`; dword when `addr[2:0]≠0`. It goes to RESP with `resp_err=1` and `resp_rdata=0`, with no memory cycle.
- **States:** IDLE, RD, MERGE, WR, RESP (Moore; `MemRead`=1 only in RD, `MemWrite`=1 only in WR).
  - IDLE → RESP on a misaligned accept.
  - IDLE → RD for a load or a sub-dword store.
  - IDLE → WR for a dword store, with `Write_Data`=`req_wdata`.
  - RD → RESP for a load: the result register is loaded at the end of RD.
  - RD → MERGE for a store: `Read_Data` is captured at the end of RD.
  - MERGE → WR: the size-wide slice of `req_wdata` replaces bytes `off..off+size-1` of the captured doubleword. All other bytes are unchanged.
  - WR → RESP.
  - RESP → IDLE. `resp_valid`=1 for exactly this one cycle.
- **Load result.** Shift `Read_Data` right by `8*off`, truncate to the size, then sign-extend from the top bit, or zero-extend if `req_unsigned`.
- **Output registers.** `Mem_Addr` and `Write_Data` are registers that hold their last value outside RD/WR. `resp_rdata` and `resp_err` hold until the next RESP.
- **Back-to-back requests.** No pipelining: the next request can be accepted in the cycle after RESP, i.e. in IDLE.

## Timing
- **Reset values:** all outputs 0, except `req_ready`=1 in the first cycle after reset release. State resets to IDLE.
- **Latency**, with accept at edge T, so the block is in state X during cycle T+1:
  - load: RD in T+1, RESP in T+2.
  - dword store: WR in T+1, RESP in T+2.
  - sub-dword store: RD T+1, MERGE T+2, WR T+3, RESP T+4.
  - misaligned: RESP in T+1.
- `req_ready` is 0 from the cycle after accept through RESP inclusive.
- `req_valid` while not ready is ignored. The requester must hold it until accepted; there is no queueing.
- **Reset mid-operation:** the state returns to IDLE at the edge where `reset` is sampled high.
  - A store reset in RD or MERGE performs no write.
  - A store in WR during the reset edge still commits, since memory samples `MemWrite` at that same edge. `MemWrite` is 0 from the next cycle.
  - No `resp_valid` is produced for an aborted request.
- `req_*` inputs are don't-care except in IDLE.

## Test plan
- **Dword store then load.** Store `0x0123456789ABCDEF` to addr 0x10, then load dword from 0x10.
  - Store: `MemWrite` for one cycle, 1 cycle after accept, with `Mem_Addr`=0x10.
  - Load: `resp_rdata`=`0x0123456789ABCDEF`, `resp_valid` 2 cycles after accept.
- **Byte store merge.** Preload 0x10 with `0x0123456789ABCDEF`; store byte 0xAA to addr 0x13.
  - Sequence is RD, MERGE, WR, with WR `Write_Data`=`0x01234567AAABCDEF`.
  - `resp_valid` 4 cycles after accept.
- **Sign/zero extension.** Load byte at 0x13 returns `0xFFFFFFFFFFFFFFAA`; with `req_unsigned`=1 it returns `0xAA`. Load half at 0x16 returns `0x0123`. Load word at 0x14 returns `0x01234567`.
- **Misaligned.** Word load at 0x12 and dword store at 0x0C each give `resp_err`=1 one cycle after accept. `MemRead`/`MemWrite` stay 0 and memory is unchanged.
- **Handshake.** Hold `req_valid` high with 3 queued stores. Each is accepted only when `req_ready`=1, with no lost or duplicated request, and memory holds all three values.
- **Reset abort.** Assert `reset` during MERGE of a half store to 0x20: no write occurs (0x20 is unchanged) and there is no `resp_valid`. Next cycle: `req_ready`=1 and all other outputs are 0.
